// File: rtl/tff_pkg.sv
// ============================================================================
//  Module      : tff_pkg
//  Description : Shared mode encodings and modulus helper for tff_counter_n.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tff_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_UP     = 2'b10;
    localparam logic [1:0] MODE_DOWN   = 2'b11;

    // Effective modulus: MOD, or 2**width when MOD is zero.
    function automatic longint unsigned tff_modv(input int unsigned width,
                                                 input int unsigned modulus);
        if (modulus == 0)
            return 64'd1 << width;
        return 64'(modulus);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tff_bit.sv
// ============================================================================
//  Module      : tff_bit
//  Description : Single T flip-flop with asynchronous active-low reset to 0.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tff_bit (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_t,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_q <= 1'b0;
        else if (i_t)
            r_q <= ~r_q;
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/tff_counter_n.sv
// ============================================================================
//  Module      : tff_counter_n
//  Description : WIDTH-bit T flip-flop register with hold, per-bit toggle and
//                modulo-MOD up/down counting, load, terminal count and wrap.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tff_counter_n
    import tff_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_t,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tc,
    output logic             o_wrap
);

    localparam logic [WIDTH:0]   c_modv = (WIDTH+1)'(tff_modv(WIDTH, MOD));
    localparam logic [WIDTH-1:0] c_max  = WIDTH'(c_modv - 1'b1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_tv;
    logic [WIDTH-1:0] w_din_clamped;
    logic             w_above;
    logic             w_wrap_next;
    logic             r_wrap;

    // A full-range modulus can never be exceeded, so skip the range checks.
    generate
        if (MOD == 0) begin : g_full_range
            assign w_above       = 1'b0;
            assign w_din_clamped = i_din;
        end else begin : g_partial_range
            assign w_above       = (w_q > c_max);
            assign w_din_clamped = (i_din > c_max) ? c_max : i_din;
        end
    endgenerate

    always_comb begin
        w_q_next    = w_q;
        w_wrap_next = r_wrap;
        if (i_load) begin
            w_q_next    = w_din_clamped;
            w_wrap_next = 1'b0;
        end else if (i_enable) begin
            case (i_mode)
                MODE_HOLD: begin
                    w_wrap_next = 1'b0;
                end
                MODE_TOGGLE: begin
                    w_q_next    = w_q ^ i_t;
                    w_wrap_next = 1'b0;
                end
                MODE_UP: begin
                    if (w_above || (w_q == c_max)) begin
                        w_q_next    = '0;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_q_next    = w_q + WIDTH'(1);
                        w_wrap_next = 1'b0;
                    end
                end
                default: begin
                    if (w_above || (w_q == '0)) begin
                        w_q_next    = c_max;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_q_next    = w_q - WIDTH'(1);
                        w_wrap_next = 1'b0;
                    end
                end
            endcase
        end
    end

    // Each flop toggles exactly where the current and next state differ.
    assign w_tv = w_q ^ w_q_next;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bits
            tff_bit u_bit (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_t     (w_tv[i]),
                .o_q     (w_q[i])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_wrap <= 1'b0;
        else
            r_wrap <= w_wrap_next;
    end

    assign o_q    = w_q;
    assign o_wrap = r_wrap;
    assign o_tc   = i_rst_n & i_enable &
                    (((i_mode == MODE_UP)   & (w_q == c_max)) |
                     ((i_mode == MODE_DOWN) & (w_q == '0)));

endmodule

`default_nettype wire

// File: tb/tb_tff_counter_n.sv
// ============================================================================
//  Module      : tb_tff_counter_n
//  Description : Bench for tff_counter_n, full-range and MOD=10 instances
//                driven in parallel against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tff_counter_n;
    import tff_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       load  = 1'b0;
    logic [1:0] mode  = MODE_HOLD;
    logic [3:0] t     = '0;
    logic [3:0] din   = '0;

    logic [3:0] q0, q10;
    logic       tc0, tc10, w0, w10;

    int n_checks = 0;
    int n_pass   = 0;
    int mq[2];
    int mw[2];
    int modv[2];

    always #5 clk = ~clk;

    tff_counter_n #(.WIDTH(4), .MOD(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_mode(mode), .i_t(t),
        .i_load(load), .i_din(din), .o_q(q0), .o_tc(tc0), .o_wrap(w0)
    );

    tff_counter_n #(.WIDTH(4), .MOD(10)) u_dut10 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_mode(mode), .i_t(t),
        .i_load(load), .i_din(din), .o_q(q10), .o_tc(tc10), .o_wrap(w10)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int ref_tc(input int k);
        if (!rst_n || !en) return 0;
        if (mode == MODE_UP   && mq[k] == modv[k] - 1) return 1;
        if (mode == MODE_DOWN && mq[k] == 0)           return 1;
        return 0;
    endfunction

    // Reference behaviour at a rising edge, in plain modular arithmetic.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit oor;
            oor = (mq[k] > modv[k] - 1);
            if (!rst_n) begin
                mq[k] = 0; mw[k] = 0;
            end else if (load) begin
                mq[k] = (int'(din) < modv[k]) ? int'(din) : modv[k] - 1;
                mw[k] = 0;
            end else if (en) begin
                case (mode)
                    MODE_HOLD:   mw[k] = 0;
                    MODE_TOGGLE: begin mq[k] = mq[k] ^ int'(t); mw[k] = 0; end
                    MODE_UP: begin
                        if (oor) begin mq[k] = 0; mw[k] = 1; end
                        else begin
                            mq[k] = (mq[k] + 1) % modv[k];
                            mw[k] = (mq[k] == 0) ? 1 : 0;
                        end
                    end
                    default: begin
                        mw[k] = (oor || mq[k] == 0) ? 1 : 0;
                        mq[k] = oor ? modv[k] - 1 : (mq[k] + modv[k] - 1) % modv[k];
                    end
                endcase
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_q_m0"},   q0,  mq[0]);
        check({tag, "_q_m10"},  q10, mq[1]);
        check({tag, "_wr_m0"},  w0,  mw[0]);
        check({tag, "_wr_m10"}, w10, mw[1]);
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic [3:0] tt,
                         input logic l, input logic [3:0] d);
        en = e; mode = m; t = tt; load = l; din = d;
        #1;
        check("tc_m0",  tc0,  ref_tc(0));
        check("tc_m10", tc10, ref_tc(1));
        @(posedge clk);
        model_edge();
        #1;
        check_state("edge");
    endtask

    // Called 1ns after a rising edge; returns 2ns before the next one.
    task automatic reset_pulse();
        en = 1'b1; mode = MODE_DOWN; load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mq[0] = 0; mq[1] = 0; mw[0] = 0; mw[1] = 0;
        check("arst_q_m0",  q0,   0);
        check("arst_q_m10", q10,  0);
        check("arst_wr_m0", w0,   0);
        check("arst_wr_m10", w10, 0);
        check("arst_tc_m0", tc0,  0);
        #4 rst_n = 1'b1;
    endtask

    initial begin
        modv[0] = 16; modv[1] = 10;
        mq[0] = 0; mq[1] = 0; mw[0] = 0; mw[1] = 0;
        en = 1'b1; mode = MODE_DOWN;
        #40;
        check("rst_q_m0",  q0,   0);
        check("rst_q_m10", q10,  0);
        check("rst_wr_m0", w0,   0);
        check("rst_tc_m0", tc0,  0);
        check("rst_tc_m10", tc10, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Full-range count through the 15->0 wrap.
        for (int i = 0; i < 17; i++) drive(1'b1, MODE_UP, 4'h0, 1'b0, 4'h0);
        check("t1_final_q_m0", q0, 1);

        // Modulo-10 instance counts down through 0->9, then a clamped load.
        drive(1'b1, MODE_DOWN, 4'h0, 1'b1, 4'd3);
        for (int i = 0; i < 5; i++) drive(1'b1, MODE_DOWN, 4'h0, 1'b0, 4'h0);
        check("t2_down_q_m10", q10, 8);
        drive(1'b1, MODE_HOLD, 4'h0, 1'b1, 4'd12);
        check("t2_clamp_m10", q10, 9);

        // Toggle mode leaves range; counting up recovers with a wrap.
        drive(1'b1, MODE_HOLD, 4'h0, 1'b1, 4'd0);
        for (int i = 0; i < 3; i++) drive(1'b1, MODE_TOGGLE, 4'b1010, 1'b0, 4'h0);
        for (int i = 0; i < 2; i++) drive(1'b1, MODE_TOGGLE, 4'b0000, 1'b0, 4'h0);
        drive(1'b1, MODE_UP, 4'h0, 1'b0, 4'h0);
        check("t3_oor_q_m10",  q10, 0);
        check("t3_oor_wr_m10", w10, 1);

        // Enable low holds; load still honoured.
        for (int i = 0; i < 5; i++) drive(1'b0, MODE_UP, 4'h0, 1'b0, 4'h0);
        drive(1'b0, MODE_UP, 4'h0, 1'b1, 4'd7);
        check("t4_load_q_m0", q0, 7);

        // Load beats a wrapping count.
        drive(1'b1, MODE_HOLD, 4'h0, 1'b1, 4'd9);
        drive(1'b1, MODE_UP,   4'h0, 1'b1, 4'd5);
        check("t5_load_wins_m10", q10, 5);

        // Asynchronous reset between edges at Q=6.
        drive(1'b1, MODE_UP, 4'h0, 1'b0, 4'h0);
        reset_pulse();
        drive(1'b1, MODE_UP, 4'h0, 1'b0, 4'h0);
        check("t6_resume_q_m0", q0, 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0)
                reset_pulse();
            drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                  4'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
